boton_debouncer: RTL and testbench

- Upstream conditioning stage for the four ALU-board push-buttons.
- Per button: synchronises the raw input, rejects bounce and glitches, then outputs a clean level and a single-cycle press pulse.
- Its outputs drive top_alu's i_boton_1..i_boton_4 directly; the level or the pulse is selectable per use.
- Channels are fully independent.

---
 rtl/boton_pkg.sv | 13 +
 rtl/debounce_channel.sv | 90 +++++++++
 rtl/boton_debouncer.sv | 29 ++
 tb/tb_boton_debouncer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/boton_pkg.sv
// boton_pkg: shared FSM state encoding and default debounce length for the button conditioner
package boton_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise, debounce and edge-detect a single push-button
module debounce_channel
    import boton_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int NB_COUNT        = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_boton,
    output logic o_boton,
    output logic o_pulse
);

    localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_COUNT-1:0] ONE  = NB_COUNT'(1);

    logic [1:0]          sync;
    logic                s;
    state_t              state, state_next;
    logic [NB_COUNT-1:0] count, count_next;
    logic                boton_next, pulse_next;

    assign s = sync[1];

    // Register synchroniser, FSM state, stability counter and both outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync    <= '0;
            state   <= IDLE_LOW;
            count   <= '0;
            o_boton <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            sync    <= {sync[0], i_boton};
            state   <= state_next;
            count   <= count_next;
            o_boton <= boton_next;
            o_pulse <= pulse_next;
        end
    end

    // Accept a level change only after it has been stable for the full window
    always_comb begin
        state_next = state;
        count_next = count;
        boton_next = o_boton;
        pulse_next = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    count_next = ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    count_next = '0;
                end else if (count == LAST) begin
                    state_next = IDLE_HIGH;
                    count_next = '0;
                    boton_next = 1'b1;
                    pulse_next = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    count_next = ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    count_next = '0;
                end else if (count == LAST) begin
                    state_next = IDLE_LOW;
                    count_next = '0;
                    boton_next = 1'b0;
                end else begin
                    count_next = count + ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/boton_debouncer.sv
// boton_debouncer: independent debounced level and press pulse for each ALU-board button
module boton_debouncer
    import boton_pkg::*;
#(
    parameter int N_BOTONES       = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int NB_COUNT        = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_BOTONES-1:0] i_boton,
    output logic [N_BOTONES-1:0] o_boton,
    output logic [N_BOTONES-1:0] o_pulse
);

    for (genvar k = 0; k < N_BOTONES; k++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .NB_COUNT       (NB_COUNT)
        ) u_ch (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_boton(i_boton[k]),
            .o_boton(o_boton[k]),
            .o_pulse(o_pulse[k])
        );
    end

endmodule

// File: tb/tb_boton_debouncer.sv
// tb_boton_debouncer: directed stimulus with an event scoreboard for boton_debouncer
module tb_boton_debouncer;

    typedef struct packed {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] pls;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] boton;
    logic [3:0] o_boton, o_pulse;
    logic [3:0] prev_boton = 4'b0;
    logic       rst_at_edge = 1'b0;
    int         edges = 0;
    int         total = 0;
    int         bad = 0;
    ev_t        exp_q[$];
    logic [8:0] pat = 9'b111101101;

    boton_debouncer #(
        .N_BOTONES      (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .i_boton(boton),
        .o_boton(o_boton),
        .o_pulse(o_pulse)
    );

    always #10 clk = ~clk;

    // Edge counter and record of whether reset was applied on the latest edge
    always @(posedge clk) begin
        edges       <= edges + 1;
        rst_at_edge <= reset;
    end

    // Monitor: any change of level or any pulse is an output event matched against the queue
    always @(negedge clk) begin
        if (rst_at_edge) begin
            total++;
            if (o_boton !== 4'b0 || o_pulse !== 4'b0) begin
                bad++;
                $display("FAIL reset_state edge=%0d got boton=%b pulse=%b want 0000/0000", edges, o_boton, o_pulse);
            end
        end else if (o_pulse !== 4'b0 || o_boton !== prev_boton) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event edge=%0d got boton=%b pulse=%b want no event", edges, o_boton, o_pulse);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != edges || e.lvl !== o_boton || e.pls !== o_pulse) begin
                    bad++;
                    $display("FAIL event got edge=%0d boton=%b pulse=%b want edge=%0d boton=%b pulse=%b",
                             edges, o_boton, o_pulse, e.cyc, e.lvl, e.pls);
                end
            end
        end
        prev_boton = o_boton;
    end

    task automatic expect_ev(input int dly, input logic [3:0] lvl, input logic [3:0] pls);
        exp_q.push_back('{cyc: edges + dly, lvl: lvl, pls: pls});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        boton = 4'b1111;
        wait_neg(3);
        reset = 1'b0;
        expect_ev(6, 4'b1111, 4'b1111);
        wait_neg(10);
        boton = 4'b0000;
        expect_ev(6, 4'b0000, 4'b0000);
        wait_neg(10);
        boton = 4'b0001;
        expect_ev(6, 4'b0001, 4'b0001);
        wait_neg(10);
        boton = 4'b0000;
        expect_ev(6, 4'b0000, 4'b0000);
        wait_neg(10);
        expect_ev(11, 4'b0010, 4'b0010);
        for (int i = 0; i < 9; i++) begin
            boton[1] = pat[i];
            @(negedge clk);
        end
        wait_neg(5);
        boton = 4'b0000;
        expect_ev(6, 4'b0000, 4'b0000);
        wait_neg(10);
        boton = 4'b0100;
        wait_neg(3);
        boton = 4'b0000;
        wait_neg(10);
        boton = 4'b1000;
        expect_ev(6, 4'b1000, 4'b1000);
        wait_neg(20);
        boton = 4'b0000;
        expect_ev(6, 4'b0000, 4'b0000);
        wait_neg(10);
        boton = 4'b1000;
        expect_ev(6, 4'b1000, 4'b1000);
        wait_neg(10);
        boton = 4'b0000;
        expect_ev(6, 4'b0000, 4'b0000);
        wait_neg(10);
        boton = 4'b0001;
        wait_neg(4);
        reset = 1'b1;
        wait_neg(1);
        reset = 1'b0;
        expect_ev(6, 4'b0001, 4'b0001);
        wait_neg(10);
        boton = 4'b0000;
        expect_ev(6, 4'b0000, 4'b0000);
        wait_neg(10);
        @(posedge clk);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event got none want edge=%0d boton=%b pulse=%b", e.cyc, e.lvl, e.pls);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
